// File: rtl/pulse_train_pkg.sv
// Shared types and defaults for the multi-channel pulse-train generator.
package pulse_train_pkg;

    typedef enum logic {
        PT_IDLE = 1'b0,
        PT_RUN  = 1'b1
    } pt_state_e;

    localparam int unsigned PT_CNT_W = 16;

endpackage : pulse_train_pkg

// File: rtl/pulse_train_channel.sv
// One generator channel: period/high-time shadow registers, a period counter
// and an IDLE/RUN state machine with registered waveform, tick and done.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   PT_IDLE | stopped, outputs low, waiting for enable (re-armed)
//   PT_RUN  | counting through the latched period, busy high
module pulse_train_channel
    import pulse_train_pkg::*;
#(
    parameter int unsigned CNT_W = PT_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             oneshot_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] high_time_i,
    output logic             wave_o,
    output logic             tick_o,
    output logic             done_o,
    output logic             busy_o
);

    pt_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic             os_q, os_d;
    logic             armed_q, armed_d;
    logic             wave_q, wave_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_last;
    logic             start_ok;

    assign cnt_inc  = cnt_q + 1'b1;
    assign cnt_last = per_q - 1'b1;
    assign start_ok = (period_i != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        hi_d    = hi_q;
        os_d    = os_q;
        armed_d = armed_q;
        wave_d  = 1'b0;
        tick_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            PT_IDLE: begin
                if (!enable_i) begin
                    armed_d = 1'b1;
                end else if (armed_q && start_ok) begin
                    state_d = PT_RUN;
                    cnt_d   = '0;
                    per_d   = period_i;
                    hi_d    = high_time_i;
                    os_d    = oneshot_i;
                    tick_d  = 1'b1;
                    wave_d  = (high_time_i != '0);
                end
            end

            PT_RUN: begin
                if (!enable_i) begin
                    // Abort wins over a coincident wrap: no done, waveform low.
                    state_d = PT_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != cnt_last) begin
                    cnt_d  = cnt_inc;
                    wave_d = (cnt_inc < hi_q);
                end else if (os_q) begin
                    state_d = PT_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    armed_d = 1'b0;
                end else if (!start_ok) begin
                    state_d = PT_IDLE;
                    cnt_d   = '0;
                end else begin
                    // Config is only picked up here, at the period boundary.
                    cnt_d  = '0;
                    per_d  = period_i;
                    hi_d   = high_time_i;
                    tick_d = 1'b1;
                    wave_d = (high_time_i != '0);
                end
            end

            default: begin
                state_d = PT_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= PT_IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            hi_q    <= '0;
            os_q    <= 1'b0;
            armed_q <= 1'b1;
            wave_q  <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            hi_q    <= hi_d;
            os_q    <= os_d;
            armed_q <= armed_d;
            wave_q  <= wave_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign wave_o = wave_q;
    assign tick_o = tick_q;
    assign done_o = done_q;
    assign busy_o = (state_q == PT_RUN);

endmodule : pulse_train_channel

// File: rtl/pulse_train_gen.sv
// Multi-channel pulse-train generator: independent channels sharing one clock,
// with packed per-channel period / high-time buses.
module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CNT_W    = PT_CNT_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       oneshot,
    input  logic [CHANNELS*CNT_W-1:0] period,
    input  logic [CHANNELS*CNT_W-1:0] high_time,
    output logic [CHANNELS-1:0]       wave_out,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS-1:0]       busy
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pulse_train_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk_i      (clock),
            .rst_i      (reset),
            .enable_i   (enable[g]),
            .oneshot_i  (oneshot[g]),
            .period_i   (period[g*CNT_W +: CNT_W]),
            .high_time_i(high_time[g*CNT_W +: CNT_W]),
            .wave_o     (wave_out[g]),
            .tick_o     (tick[g]),
            .done_o     (done[g]),
            .busy_o     (busy[g])
        );
    end

endmodule : pulse_train_gen

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: channel-0 cycle table plus a
// two-channel free-run sequence with an arithmetic tick/wave model.
module tb_pulse_train_gen;

    localparam int unsigned CH = 2;
    localparam int unsigned CW = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic [CH-1:0]    enable;
    logic [CH-1:0]    oneshot;
    logic [CH*CW-1:0] period;
    logic [CH*CW-1:0] high_time;
    logic [CH-1:0]    wave_out;
    logic [CH-1:0]    tick;
    logic [CH-1:0]    done;
    logic [CH-1:0]    busy;

    pulse_train_gen #(.CHANNELS(CH), .CNT_W(CW)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .oneshot  (oneshot),
        .period   (period),
        .high_time(high_time),
        .wave_out (wave_out),
        .tick     (tick),
        .done     (done),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          rst;
        logic          en;
        logic          os;
        logic [CW-1:0] per;
        logic [CW-1:0] hi;
        logic          w;
        logic          t;
        logic          d;
        logic          b;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic void add(input logic rst, input logic en, input logic os,
                                input int per, input int hi,
                                input logic w, input logic t, input logic d, input logic b);
        vec_t v;
        v.rst = rst; v.en = en; v.os = os;
        v.per = CW'(per); v.hi = CW'(hi);
        v.w = w; v.t = t; v.d = d; v.b = b;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got wave/tick/done/busy=%b_%b_%b_%b required %b_%b_%b_%b",
                     name, got[7:6], got[5:4], got[3:2], got[1:0],
                     exp[7:6], exp[5:4], exp[3:2], exp[1:0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int coinc;

        //   rst en os per hi | w t d b
        add(1, 0, 0, 5, 2,  0, 0, 0, 0);  // reset
        add(0, 1, 0, 5, 2,  1, 1, 0, 1);  // free-run 5/2 start
        add(0, 1, 0, 5, 2,  1, 0, 0, 1);
        add(0, 1, 0, 5, 2,  0, 0, 0, 1);
        add(0, 1, 0, 5, 2,  0, 0, 0, 1);
        add(0, 1, 0, 5, 2,  0, 0, 0, 1);
        add(0, 1, 0, 5, 2,  1, 1, 0, 1);  // second tick after 5
        add(0, 1, 0, 3, 2,  1, 0, 0, 1);  // period changed mid-period
        add(0, 1, 0, 3, 2,  0, 0, 0, 1);
        add(0, 1, 0, 3, 2,  0, 0, 0, 1);
        add(0, 1, 0, 3, 2,  0, 0, 0, 1);
        add(0, 1, 0, 3, 2,  1, 1, 0, 1);  // still 5 apart
        add(0, 1, 0, 3, 2,  1, 0, 0, 1);
        add(0, 1, 0, 3, 2,  0, 0, 0, 1);
        add(0, 1, 0, 3, 2,  1, 1, 0, 1);  // now 3 apart
        add(0, 1, 0, 3, 2,  1, 0, 0, 1);
        add(0, 1, 0, 3, 2,  0, 0, 0, 1);  // cnt=2
        add(0, 0, 0, 3, 2,  0, 0, 0, 0);  // enable dropped: no done
        add(0, 0, 0, 3, 2,  0, 0, 0, 0);
        add(0, 1, 1, 4, 1,  1, 1, 0, 1);  // one-shot 4/1
        add(0, 1, 1, 4, 1,  0, 0, 0, 1);
        add(0, 1, 1, 4, 1,  0, 0, 0, 1);
        add(0, 1, 1, 4, 1,  0, 0, 0, 1);
        add(0, 1, 1, 4, 1,  0, 0, 1, 0);  // done in 5th cycle
        add(0, 1, 1, 4, 1,  0, 0, 0, 0);  // no retrigger on level
        add(0, 1, 1, 4, 1,  0, 0, 0, 0);
        add(0, 0, 1, 4, 1,  0, 0, 0, 0);  // re-arm
        add(0, 1, 1, 4, 1,  1, 1, 0, 1);  // retrigger
        add(0, 0, 1, 4, 1,  0, 0, 0, 0);  // abort one-shot: no done
        add(0, 1, 0, 1, 1,  1, 1, 0, 1);  // period 1
        add(0, 1, 0, 1, 1,  1, 1, 0, 1);
        add(0, 1, 0, 1, 1,  1, 1, 0, 1);
        add(0, 1, 0, 0, 1,  0, 0, 0, 0);  // period 0 at wrap -> idle
        add(0, 1, 0, 0, 1,  0, 0, 0, 0);  // period 0 stays idle
        add(0, 1, 0, 4, 7,  1, 1, 0, 1);  // hi >= period
        add(0, 1, 0, 4, 7,  1, 0, 0, 1);
        add(0, 1, 0, 4, 7,  1, 0, 0, 1);
        add(0, 1, 0, 4, 7,  1, 0, 0, 1);
        add(0, 1, 0, 4, 7,  1, 1, 0, 1);
        add(0, 1, 0, 4, 7,  1, 0, 0, 1);
        add(0, 1, 0, 4, 7,  1, 0, 0, 1);  // cnt=2
        add(1, 1, 0, 4, 7,  0, 0, 0, 0);  // reset mid-run
        add(0, 0, 0, 4, 7,  0, 0, 0, 0);

        reset     = 1'b1;
        enable    = '0;
        oneshot   = '0;
        period    = '0;
        high_time = '0;

        for (int i = 0; i < vecs.size(); i++) begin
            reset     = vecs[i].rst;
            enable    = {1'b0, vecs[i].en};
            oneshot   = {1'b0, vecs[i].os};
            period    = {CW'(0), vecs[i].per};
            high_time = {CW'(0), vecs[i].hi};
            @(posedge clock);
            #1;
            check($sformatf("vec%0d", i),
                  {wave_out, tick, done, busy},
                  {1'b0, vecs[i].w, 1'b0, vecs[i].t, 1'b0, vecs[i].d, 1'b0, vecs[i].b});
        end

        // Two channels, periods 3 and 7, free-running from the same edge.
        reset     = 1'b0;
        oneshot   = 2'b00;
        period    = {CW'(7), CW'(3)};
        high_time = {CW'(3), CW'(1)};
        enable    = 2'b11;
        coinc     = 0;
        for (int c = 0; c < 42; c++) begin
            logic [1:0] ew, et;
            @(posedge clock);
            #1;
            ew = {logic'((c % 7) < 3), logic'((c % 3) < 1)};
            et = {logic'((c % 7) == 0), logic'((c % 3) == 0)};
            if (tick == 2'b11) coinc++;
            check($sformatf("dual_c%0d", c), {wave_out, tick, done, busy},
                  {ew, et, 2'b00, 2'b11});
        end
        n_vec++;
        if (coinc != 2) begin
            n_miss++;
            $display("FAIL dual_coincident_ticks: got %0d required 2", coinc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_pulse_train_gen

// File: doc/pulse_train_gen.md
# pulse_train_gen

Synthesizable, parametrised multi-channel clock/pulse generator for the camera datapath. Produces per-channel programmable-period, programmable-duty waveforms plus one-cycle period ticks, in free-running or one-shot mode. Supplies the sensor master clock and frame/line timing strobes. Replaces fixed-delay simulation clocking with register-controlled timing derived from the single system clock.

## Interface
- `CHANNELS`, default 2: number of independent generator channels.
- `CNT_W`, default 16: width of the period and high-time counters.

Ports:
- `clock`  in  1: system clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `enable`  in  CHANNELS: per-channel run request, level-sensitive.
- `oneshot`  in  CHANNELS: per-channel mode; 1 = run one period then stop, 0 = free-run.
- `period`  in  CHANNELS*CNT_W: period in clocks; channel i uses slice [i*CNT_W +: CNT_W].
- `high_time`  in  CHANNELS*CNT_W: clocks the waveform is high per period; same slicing.
- `wave_out`  out  CHANNELS: registered waveform.
- `tick`  out  CHANNELS: one-cycle pulse on the first cycle of each period.
- `done`  out  CHANNELS: one-cycle pulse when a one-shot period completes.
- `busy`  out  CHANNELS: channel in RUN.

## Operation
- Each channel has two states: IDLE and RUN.
- Each channel holds a counter `cnt` and shadow registers `per_a` and `hi_a`.
- Reset: all channels go to IDLE with `cnt`=0 and `per_a`=`hi_a`=0. Outputs `wave_out`, `tick`, `done` and `busy` are all 0.
- IDLE→RUN when `enable[i]`=1 and `period`≥1.
  - On that edge, `per_a` and `hi_a` load from the inputs and `cnt`=0.
  - Outputs on the same edge: `tick`=1, `busy`=1, `wave_out`=(`high_time`>0).
- RUN, when `cnt`<`per_a`−1: `cnt`+1. `wave_out`=(`cnt_next`<`hi_a`). `tick`=0.
- RUN, when `cnt`=`per_a`−1 (wrap):
  - Free-run:
    - `cnt`=0 and `tick`=1.
    - `per_a` and `hi_a` reload from the inputs. New config takes effect only at period boundaries, so there are no runt pulses.
    - If the new `period`=0, go to IDLE instead.
  - One-shot: go to IDLE with `done`=1, `wave_out`=0, `busy`=0.
- `enable[i]`=0 in RUN: go to IDLE on the next edge with `wave_out`=0 and no `done`. This takes priority over the wrap.
- A one-shot channel re-arms only after `enable` is seen low in IDLE. It needs an edge, not a level, so it does not retrigger continuously.
- Boundary cases:
  - `period`=0: the channel stays IDLE.
  - `period`=1: `tick` is asserted every cycle. `wave_out` is constantly 1 if `hi_a`≥1.
  - `hi_a`=0: `wave_out` is constantly 0.
  - `hi_a`≥`per_a`: `wave_out` is constantly 1 while in RUN.
- Comparisons are unsigned, CNT_W-bit. `cnt` never exceeds `per_a`−1. No overflow is possible.
- `oneshot` is sampled on the IDLE→RUN edge and held for that run.
- Channels are fully independent. Same-cycle events on different channels do not interact.

## Timing
- All outputs are registered. No combinational path runs from inputs to outputs.
- Latency from `enable` high (sampled at edge k) to the first `tick` and first `wave_out` high: visible after edge k (1 clock).
- In free-run, the `tick` spacing is exactly `per_a` clocks. `wave_out` is high for `hi_a` clocks starting with the tick cycle.
- `done` coincides with the cycle after the last period cycle. `busy` falls on the same edge.
- Reset mid-run: the channel returns to IDLE on the next edge, with outputs 0 on that edge.

## Structure
- Package `pulse_train_pkg`:
  - State enum {IDLE, RUN}.
  - Default `CNT_W` constant.
- Sub-module `pulse_train_channel`:
  - Parametrised by `CNT_W`.
  - Contains one counter, the shadow registers and the state machine.
- Top level: a generate loop of `CHANNELS` instances, plus port slicing.

## Test plan
- Free-run, CNT_W=16, `period`=5, `high_time`=2: `tick` every 5 clocks. `wave_out` pattern is 1,1,0,0,0, repeating. `busy` is held at 1.
- One-shot, `period`=4, `high_time`=1, `enable` held high: exactly one `tick`. `wave_out` is 1,0,0,0. `done` fires in the 5th cycle. No retrigger until `enable` toggles low then high.
- Change `period` from 5 to 3 mid-period: the current period completes at 5 clocks, and ticks are spaced 3 clocks apart afterwards.
- Edge cases:
  - `period`=1, `high_time`=1: `tick` and `wave_out` constantly 1.
  - `period`=0: `busy` stays 0.
  - `high_time`=7 with `period`=4: `wave_out` constantly 1.
- Drop `enable` at `cnt`=2, and separately assert `reset` at `cnt`=2: in both cases all outputs are 0 on the next edge, with no `done`.
- CHANNELS=2 with channel 0 at `period`=3 and channel 1 at `period`=7: independent tick trains, with a coincident tick every 21 clocks and no cross-effects.
